// File: rtl/dither_pixel_unpack.sv
// Expands packed Y4/Y1 framebuffer words into a Y8 multi-pixel stream with line/frame markers.
// Latency: one cycle from word accept to first beat; one word in flight, refilled in the cycle its last beat fires.
// Backpressure: out_ready low holds the beat and counters; in_ready low while a word still has beats pending.
module dither_pixel_unpack #(
    parameter int OUTPUT_BITS = 8,
    parameter int PACKED_BITS = 4,
    parameter int PIXEL_RATE  = 4,
    parameter int WORD_BITS   = 32,
    parameter int H_BEATS     = 400,
    parameter int V_LINES     = 1200,
    parameter int CNT_BITS    = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic [WORD_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [OUTPUT_BITS*PIXEL_RATE-1:0] out_pixels,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sol,
    output logic                              out_eol,
    output logic                              out_sof,
    output logic                              out_eof
);

    localparam int SLICE_BITS = PACKED_BITS * PIXEL_RATE;
    localparam int BPW        = WORD_BITS / SLICE_BITS;
    localparam int BIDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int REP        = OUTPUT_BITS / PACKED_BITS;

    localparam logic [BIDX_W-1:0]   BIDX_LAST = BIDX_W'(BPW - 1);
    localparam logic [CNT_BITS-1:0] X_LAST    = CNT_BITS'(H_BEATS - 1);
    localparam logic [CNT_BITS-1:0] Y_LAST    = CNT_BITS'(V_LINES - 1);

    logic [WORD_BITS-1:0]  word_q, word_d;
    logic                  full_q, full_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic [CNT_BITS-1:0]   x_q, x_d;
    logic [CNT_BITS-1:0]   y_q, y_d;

    logic                  fire;
    logic                  last_beat;
    logic                  accept;
    logic [SLICE_BITS-1:0] slice;

    always_ff @(posedge clk) begin
        word_q <= word_d;
        full_q <= full_d;
        bidx_q <= bidx_d;
        x_q    <= x_d;
        y_q    <= y_d;
    end

    always_comb begin
        out_valid = full_q && !rst;
        fire      = out_valid && out_ready;
        last_beat = (bidx_q == BIDX_LAST);
        in_ready  = !rst && !frame_start && (!full_q || (fire && last_beat));
        accept    = in_valid && in_ready;
    end

    always_comb begin
        word_d = word_q;
        full_d = full_q;
        bidx_d = bidx_q;
        x_d    = x_q;
        y_d    = y_q;
        if (rst) begin
            word_d = '0;
            full_d = 1'b0;
            bidx_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else if (frame_start) begin
            full_d = 1'b0;
            bidx_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else begin
            if (fire) begin
                if (last_beat) begin
                    bidx_d = '0;
                    full_d = 1'b0;
                end else begin
                    bidx_d = bidx_q + BIDX_W'(1);
                end
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_BITS'(1);
                end else begin
                    x_d = x_q + CNT_BITS'(1);
                end
            end
            // A refill lands in the same cycle the last beat leaves, so no bubble.
            if (accept) begin
                word_d = in_data;
                full_d = 1'b1;
                bidx_d = '0;
            end
        end
    end

    // Leftmost stored pixel (MSBs of the slice) goes to the top output slot.
    always_comb begin
        slice      = word_q[WORD_BITS-1-int'(bidx_q)*SLICE_BITS -: SLICE_BITS];
        out_pixels = '0;
        if (out_valid) begin
            for (int k = 0; k < PIXEL_RATE; k++) begin
                out_pixels[(PIXEL_RATE-1-k)*OUTPUT_BITS +: OUTPUT_BITS] =
                    {REP{slice[SLICE_BITS-1-k*PACKED_BITS -: PACKED_BITS]}};
            end
        end
    end

    always_comb begin
        out_sol = out_valid && (x_q == '0);
        out_eol = out_valid && (x_q == X_LAST);
        out_sof = out_sol && (y_q == '0);
        out_eof = out_eol && (y_q == Y_LAST);
    end

endmodule

// File: tb/tb_dither_pixel_unpack.sv
// Directed bench: Y4 instance with a tiny 4x2 frame for table-driven framing checks, Y1 instance for 1-bit expansion.
module tb_dither_pixel_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;

    logic [31:0] d4 = '0, d1 = '0;
    logic        iv4 = 1'b0, iv1 = 1'b0;
    logic        ir4, ir1;
    logic [31:0] p4, p1;
    logic        v4, v1;
    logic        or4 = 1'b0, or1 = 1'b0;
    logic        sol4, eol4, sof4, eof4;
    logic        sol1, eol1, sof1, eof1;
    logic [3:0]  f4, f1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign f4 = {sol4, eol4, sof4, eof4};
    assign f1 = {sol1, eol1, sof1, eof1};

    dither_pixel_unpack #(.PACKED_BITS(4), .H_BEATS(4), .V_LINES(2)) u4 (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_data(d4), .in_valid(iv4), .in_ready(ir4),
        .out_pixels(p4), .out_valid(v4), .out_ready(or4),
        .out_sol(sol4), .out_eol(eol4), .out_sof(sof4), .out_eof(eof4)
    );

    dither_pixel_unpack #(.PACKED_BITS(1), .H_BEATS(8), .V_LINES(2)) u1 (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_data(d1), .in_valid(iv1), .in_ready(ir1),
        .out_pixels(p1), .out_valid(v1), .out_ready(or1),
        .out_sol(sol1), .out_eol(eol1), .out_sof(sof1), .out_eof(eof1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Y4 bit-replication model: nibble n -> byte {n,n}.
    function automatic logic [31:0] expand4(input logic [31:0] w, input int beat);
        logic [15:0] s;
        logic [31:0] r;
        s = (beat == 0) ? w[31:16] : w[15:0];
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[(3-k)*8 +: 8] = {s[15-4*k -: 4], s[15-4*k -: 4]};
        end
        return r;
    endfunction

    typedef struct {
        logic        rst;
        logic        fs;
        logic        iv;
        logic        ordy;
        logic [31:0] data;
        logic        e_vld;
        logic        e_ir;
        logic [31:0] e_pix;
        logic [3:0]  e_flg;   // {sol, eol, sof, eof}
    } vec_t;

    vec_t tbl[23];

    logic [31:0] words[6];
    logic [31:0] exp_beats[12];
    logic [31:0] stall_pix;
    logic        have_stall;
    int          widx, got;

    initial begin
        // rst fs iv or data         vld ir pix           flags
        tbl[0]  = '{1, 0, 1, 1, 32'h00000000, 0, 0, 32'h00000000, 4'b0000};
        tbl[1]  = '{0, 0, 1, 1, 32'h01234567, 0, 1, 32'h00000000, 4'b0000};
        tbl[2]  = '{0, 0, 1, 1, 32'h89ABCDEF, 1, 0, 32'h00112233, 4'b1010};
        tbl[3]  = '{0, 0, 1, 1, 32'h89ABCDEF, 1, 1, 32'h44556677, 4'b0000};
        tbl[4]  = '{0, 0, 1, 1, 32'hFEDCBA98, 1, 0, 32'h8899AABB, 4'b0000};
        tbl[5]  = '{0, 0, 1, 1, 32'hFEDCBA98, 1, 1, 32'hCCDDEEFF, 4'b0100};
        tbl[6]  = '{0, 0, 1, 1, 32'h76543210, 1, 0, 32'hFFEEDDCC, 4'b1000};
        tbl[7]  = '{0, 0, 1, 1, 32'h76543210, 1, 1, 32'hBBAA9988, 4'b0000};
        tbl[8]  = '{0, 0, 0, 1, 32'h00000000, 1, 0, 32'h77665544, 4'b0000};
        tbl[9]  = '{0, 0, 0, 1, 32'h00000000, 1, 1, 32'h33221100, 4'b0101};
        tbl[10] = '{0, 0, 1, 1, 32'h13579BDF, 0, 1, 32'h00000000, 4'b0000};
        tbl[11] = '{0, 0, 1, 1, 32'h2468ACE0, 1, 0, 32'h11335577, 4'b1010};
        tbl[12] = '{0, 0, 1, 1, 32'h2468ACE0, 1, 1, 32'h99BBDDFF, 4'b0000};
        tbl[13] = '{0, 1, 1, 1, 32'hDEADBEEF, 1, 0, 32'h22446688, 4'b0000};
        tbl[14] = '{0, 0, 1, 1, 32'hDEADBEEF, 0, 1, 32'h00000000, 4'b0000};
        tbl[15] = '{0, 0, 0, 0, 32'h00000000, 1, 0, 32'hDDEEAADD, 4'b1010};
        tbl[16] = '{0, 0, 0, 0, 32'h00000000, 1, 0, 32'hDDEEAADD, 4'b1010};
        tbl[17] = '{0, 0, 0, 1, 32'h00000000, 1, 0, 32'hDDEEAADD, 4'b1010};
        tbl[18] = '{1, 0, 1, 1, 32'h11111111, 0, 0, 32'h00000000, 4'b0000};
        tbl[19] = '{0, 0, 1, 1, 32'hC0C0C0C0, 0, 1, 32'h00000000, 4'b0000};
        tbl[20] = '{0, 0, 0, 1, 32'h00000000, 1, 0, 32'hCC00CC00, 4'b1010};
        tbl[21] = '{0, 0, 0, 1, 32'h00000000, 1, 1, 32'hCC00CC00, 4'b0000};
        tbl[22] = '{0, 0, 0, 1, 32'h00000000, 0, 1, 32'h00000000, 4'b0000};

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            frame_start = tbl[i].fs;
            iv4         = tbl[i].iv;
            or4         = tbl[i].ordy;
            d4          = tbl[i].data;
            #1;
            chk($sformatf("y4_valid[%0d]", i), {31'b0, v4}, {31'b0, tbl[i].e_vld});
            chk($sformatf("y4_in_ready[%0d]", i), {31'b0, ir4}, {31'b0, tbl[i].e_ir});
            if (tbl[i].e_vld) begin
                chk($sformatf("y4_pixels[%0d]", i), p4, tbl[i].e_pix);
                chk($sformatf("y4_flags[%0d]", i), {28'b0, f4}, {28'b0, tbl[i].e_flg});
            end
        end
        iv4 = 1'b0;

        // Y1: one word with 8 beats, back-to-back with a second word.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("y1_rst_valid", {31'b0, v1}, 32'd0);
        chk("y1_rst_in_ready", {31'b0, ir1}, 32'd0);
        @(negedge clk);
        rst = 1'b0; iv1 = 1'b1; or1 = 1'b1; d1 = 32'hA0000000;
        #1;
        chk("y1_accept_ready", {31'b0, ir1}, 32'd1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (b == 7) d1 = 32'h80000001;
            #1;
            chk($sformatf("y1_w0_valid[%0d]", b), {31'b0, v1}, 32'd1);
            chk($sformatf("y1_w0_pix[%0d]", b), p1, (b == 0) ? 32'hFF00FF00 : 32'h0);
            chk($sformatf("y1_w0_in_ready[%0d]", b), {31'b0, ir1}, (b == 7) ? 32'd1 : 32'd0);
            chk($sformatf("y1_w0_flags[%0d]", b), {28'b0, f1},
                (b == 0) ? 32'b1010 : ((b == 7) ? 32'b0100 : 32'b0000));
        end
        @(negedge clk);
        iv1 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b != 0) @(negedge clk);
            #1;
            chk($sformatf("y1_w1_pix[%0d]", b), p1,
                (b == 0) ? 32'hFF000000 : ((b == 7) ? 32'h000000FF : 32'h0));
            chk($sformatf("y1_w1_flags[%0d]", b), {28'b0, f1},
                (b == 0) ? 32'b1000 : ((b == 7) ? 32'b0101 : 32'b0000));
            if (b != 7) #3;
        end
        @(negedge clk);
        #1;
        chk("y1_drained_valid", {31'b0, v1}, 32'd0);

        // Backpressure: out_ready toggles 1010..., in_valid held high.
        words[0] = 32'h0F1E2D3C; words[1] = 32'h4B5A6978; words[2] = 32'h8796A5B4;
        words[3] = 32'hC3D2E1F0; words[4] = 32'h13243546; words[5] = 32'h5768798A;
        for (int w = 0; w < 6; w++) begin
            exp_beats[2*w]     = expand4(words[w], 0);
            exp_beats[2*w + 1] = expand4(words[w], 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        widx = 0; got = 0; have_stall = 1'b0; stall_pix = '0;
        for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
            if (cyc != 0) @(negedge clk);
            or4 = (cyc % 2 == 0);
            iv4 = (widx < 6);
            d4  = (widx < 6) ? words[widx] : 32'h0;
            #1;
            if (v4) begin
                if (have_stall) chk($sformatf("bp_stable[%0d]", got), p4, stall_pix);
                if (ir4) chk($sformatf("bp_in_ready_rule[%0d]", got),
                             {31'b0, or4 && (got % 2 == 1)}, 32'd1);
                if (or4) begin
                    chk($sformatf("bp_beat[%0d]", got), p4, exp_beats[got]);
                    got++;
                    have_stall = 1'b0;
                end else begin
                    have_stall = 1'b1;
                    stall_pix  = p4;
                end
            end
            if (iv4 && ir4) widx++;
        end
        chk("bp_beats_seen", got, 32'd12);
        chk("bp_words_taken", widx, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
